// File: rtl/actv_seq_if.sv
// Beat streams around actv_seq: conv engine -> sequencer, sequencer <-> ReLU unit, sequencer -> consumer.
interface actv_seq_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 22,
    parameter int ROW_W      = 5,
    parameter int COL_W      = 5
);
    logic                             in_valid_i;
    logic                             in_ready_o;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data_i;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] relu_in_o;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] relu_out_i;
    logic                             out_valid_o;
    logic                             out_ready_i;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data_o;
    logic [ROW_W-1:0]                 out_row_o;
    logic [COL_W-1:0]                 out_col_o;
    logic                             out_last_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  relu_out_i,
        input  out_ready_i,
        output in_ready_o,
        output relu_in_o,
        output out_valid_o,
        output out_data_o,
        output out_row_o,
        output out_col_o,
        output out_last_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output relu_out_i,
        output out_ready_i,
        input  in_ready_o,
        input  relu_in_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_row_o,
        input  out_col_o,
        input  out_last_o
    );
endinterface

// File: rtl/actv_seq.sv
// Activation sequencer: conv beats -> 1-cycle external ReLU -> 2-entry tagged output buffer; accept->out_valid 2 cycles.
// in_ready is credit based (buffer occupancy + beat in flight), so output backpressure never overflows the buffer.

module actv_seq_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_vld = (count_q != '0);
    assign pop     = pop_vld && pop_rdy;
    // Head is zeroed when empty so the consumer never sees stale beats.
    assign pop_dat = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_vld) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module actv_seq #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 22,
    parameter int FMAP_W     = 28,
    parameter int FMAP_H     = 28
) (
    input  logic      seq_clk,
    input  logic      seq_rst_b,
    input  logic      start_i,
    input  logic      abort_i,
    output logic      busy_o,
    output logic      done_o,
    actv_seq_if.slave bus
);
    localparam int ROW_W = $clog2(FMAP_H);
    localparam int COL_W = $clog2(FMAP_W);
    localparam int BUS_W = NUM_INPUTS * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } tag_t;

    typedef struct packed {
        logic [BUS_W-1:0] dat;
        tag_t             tag;
    } beat_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             inflight_q, inflight_d;
    tag_t             tag_q, tag_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_vld;
    logic [1:0]       fifo_cnt;
    logic [2:0]       occ;
    logic             col_end;
    logic             row_end;
    beat_t            push_beat;
    beat_t            head_beat;

    assign col_end = (col_q == COL_W'(FMAP_W - NUM_INPUTS));
    assign row_end = (row_q == ROW_W'(FMAP_H - 1));

    // Occupancy after this cycle's pop, counting the beat still inside the ReLU unit.
    assign pop            = fifo_vld && bus.out_ready_i;
    assign occ            = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
    assign bus.in_ready_o = (state_q == RUN) && (occ < 3'd2);
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    assign bus.relu_in_o  = accept ? bus.in_data_i : '0;

    // ReLU result lands one cycle after acceptance; an abort discards it.
    assign push      = inflight_q && !abort_i;
    assign push_beat = '{dat: bus.relu_out_i, tag: tag_q};

    actv_seq_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (2)
    ) u_obuf (
        .clk      (seq_clk),
        .rst_n    (seq_rst_b),
        .flush    (abort_i),
        .push_vld (push),
        .push_dat (push_beat),
        .pop_rdy  (bus.out_ready_i),
        .pop_vld  (fifo_vld),
        .pop_dat  (head_beat),
        .count    (fifo_cnt)
    );

    assign bus.out_valid_o = fifo_vld;
    assign bus.out_data_o  = head_beat.dat;
    assign bus.out_row_o   = head_beat.tag.row;
    assign bus.out_col_o   = head_beat.tag.col;
    assign bus.out_last_o  = head_beat.tag.last;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        tag_d      = tag_q;
        inflight_d = accept;

        if (accept) begin
            tag_d = '{row: row_q, col: col_q, last: col_end && row_end};
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + COL_W'(NUM_INPUTS);
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN:     if (accept && col_end && row_end) state_d = DRAIN;
            DRAIN:   if (!inflight_q && (fifo_cnt == 2'd0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d    = IDLE;
            row_d      = '0;
            col_d      = '0;
            inflight_d = 1'b0;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge seq_clk or negedge seq_rst_b) begin
        if (!seq_rst_b) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            row_q      <= row_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end
endmodule

// File: tb/tb_actv_seq.sv
// Scoreboard bench for actv_seq with a registered ReLU model standing in for the external unit.
module tb_actv_seq;
    localparam int NI  = 4;
    localparam int DW  = 22;
    localparam int FW  = 28;
    localparam int FH  = 28;
    localparam int BPR = FW / NI;
    localparam int BPF = BPR * FH;
    localparam int BW  = NI * DW;

    typedef struct packed {
        logic [BW-1:0] dat;
        logic [4:0]    row;
        logic [4:0]    col;
        logic          last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;

    int    checks   = 0;
    int    errors   = 0;
    int    beat_idx = 0;
    beat_t sbq[$];
    logic [BW-1:0] pix [BPF];

    logic  acc_s, pop_s, o_rdy, o_vld, o_busy, o_done;
    beat_t obs;

    always #5 clk = ~clk;

    actv_seq_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .ROW_W(5), .COL_W(5)) bus ();

    actv_seq #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .FMAP_W(FW), .FMAP_H(FH)) dut (
        .seq_clk   (clk),
        .seq_rst_b (rst_b),
        .start_i   (start),
        .abort_i   (abort),
        .busy_o    (busy),
        .done_o    (done),
        .bus       (bus)
    );

    function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = '0;
        for (int l = 0; l < NI; l++)
            if (!v[l*DW+DW-1]) r[l*DW +: DW] = v[l*DW +: DW];
        return r;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) bus.relu_out_i <= '0;
        else        bus.relu_out_i <= relu(bus.relu_in_o);
    end

    function automatic beat_t exp_beat(input int idx, input logic [BW-1:0] d);
        beat_t e;
        e.dat  = relu(d);
        e.row  = 5'(idx / BPR);
        e.col  = 5'((idx % BPR) * NI);
        e.last = (idx == BPF - 1);
        return e;
    endfunction

    task automatic fill_pix();
        for (int i = 0; i < BPF; i++)
            for (int l = 0; l < NI; l++)
                pix[i][l*DW +: DW] = DW'($urandom);
    endtask

    task automatic step(input logic vld, input logic [BW-1:0] dat, input logic rdy,
                        input logic st, input logic ab);
        @(negedge clk);
        bus.in_valid_i  = vld;
        bus.in_data_i   = dat;
        bus.out_ready_i = rdy;
        start = st;
        abort = ab;
        #1;
        o_rdy  = bus.in_ready_o;
        o_vld  = bus.out_valid_o;
        o_busy = busy;
        o_done = done;
        obs    = '{dat: bus.out_data_o, row: bus.out_row_o, col: bus.out_col_o, last: bus.out_last_o};
        acc_s  = vld && o_rdy;
        pop_s  = o_vld && rdy;
        if (acc_s) begin
            sbq.push_back(exp_beat(beat_idx, dat));
            beat_idx++;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = '1;
        bus.out_ready_i = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, bus.in_ready_o, bus.out_valid_o, bus.out_last_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/in_rdy/out_vld/last=%b required 00000",
                     {busy, done, bus.in_ready_o, bus.out_valid_o, bus.out_last_o});
        end
        checks++;
        if (bus.relu_in_o !== '0 || bus.out_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got relu_in=%h out_data=%h required 0", bus.relu_in_o, bus.out_data_o);
        end
        checks++;
        if (bus.out_row_o !== 5'd0 || bus.out_col_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_tags: got row=%0d col=%0d required 0", bus.out_row_o, bus.out_col_o);
        end
        @(negedge clk);
        rst_b = 1'b1;
        bus.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start: got busy=%b required 1", busy);
        end
        start = 1'b0;
    endtask

    task automatic run_frame(input int vld_pct, input int rdy_pct, input int hold, input bit rand_start);
        int    npop = 0, nlast = 0, ndone = 0;
        int    last_pop = -10, done_cyc = -1, first_acc = -1, last_acc = -1;
        bit    prev_stall = 1'b0;
        beat_t prev_obs, e;
        logic  v, r, s;
        fill_pix();
        beat_idx = 0;
        sbq.delete();
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            v = (beat_idx < BPF) && ($urandom_range(99) < vld_pct);
            r = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
            s = rand_start && (npop < BPF) && ($urandom_range(1) == 1);
            step(v, pix[(beat_idx < BPF) ? beat_idx : 0], r, s, 1'b0);
            if (cyc == 0) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_start: got %b required 1", o_busy);
                end
            end
            if (acc_s) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (hold > 0 && cyc == hold - 1) begin
                checks++;
                if (beat_idx != 2 || o_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_credit: got accepted=%0d in_ready=%b required 2 and 0", beat_idx, o_rdy);
                end
            end
            if (prev_stall && o_vld) begin
                checks++;
                if (obs !== prev_obs) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h", obs, prev_obs);
                end
            end
            prev_stall = o_vld && !r;
            prev_obs   = obs;
            if (pop_s) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra: got unexpected beat %h required none", obs);
                end else begin
                    e = sbq.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL out_beat: got dat=%h row=%0d col=%0d last=%b required dat=%h row=%0d col=%0d last=%b",
                                 obs.dat, obs.row, obs.col, obs.last, e.dat, e.row, e.col, e.last);
                    end
                end
                npop++;
                nlast += int'(obs.last);
                last_pop = cyc;
            end
            if (o_done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (npop >= BPF && cyc > last_pop + 4) break;
        end
        checks++;
        if (npop != BPF) begin
            errors++;
            $display("FAIL frame_count: got %0d beats required %0d", npop, BPF);
        end
        checks++;
        if (ndone != 1 || done_cyc != last_pop + 2) begin
            errors++;
            $display("FAIL done_pulse: got %0d pulses at offset %0d required 1 at offset 2", ndone, done_cyc - last_pop);
        end
        checks++;
        if (nlast != 1) begin
            errors++;
            $display("FAIL last_count: got %0d required 1", nlast);
        end
        if (vld_pct == 100 && rdy_pct == 100 && hold == 0) begin
            checks++;
            if (last_acc - first_acc != BPF - 1) begin
                errors++;
                $display("FAIL full_rate: got span %0d required %0d", last_acc - first_acc, BPF - 1);
            end
        end
        checks++;
        if (o_busy !== 1'b0 || o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL frame_idle: got busy=%b in_ready=%b required 0 0", o_busy, o_rdy);
        end
    endtask

    task automatic test_full_frame();
        run_frame(100, 100, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(100, 100, 20, 1'b0);
    endtask

    task automatic test_random();
        run_frame(70, 60, 0, 1'b1);
    endtask

    task automatic test_sign();
        logic [BW-1:0] d, exp_d;
        bit got = 1'b0;
        d     = {22'(2**21 - 1), 22'd7, 22'd0, -22'sd5};
        exp_d = {22'(2**21 - 1), 22'd7, 22'd0, 22'd0};
        beat_idx = 0;
        sbq.delete();
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b1, d, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (pop_s) begin
                got = 1'b1;
                checks++;
                if (obs.dat !== exp_d || obs.row !== 5'd0 || obs.col !== 5'd0) begin
                    errors++;
                    $display("FAIL sign: got dat=%h row=%0d col=%0d required dat=%h row=0 col=0",
                             obs.dat, obs.row, obs.col, exp_d);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL sign_timeout: got no output required one beat");
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL sign_abort: got busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_abort();
        beat_t e;
        int    ndone = 0;
        bit    got = 1'b0;
        fill_pix();
        beat_idx = 0;
        sbq.delete();
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400 && beat_idx < 100; i++) begin
            step(1'b1, pix[beat_idx], 1'b1, 1'b0, 1'b0);
            if (pop_s) begin
                e = sbq.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL abort_pre: got %h required %h", obs, e);
                end
            end
        end
        step(1'b1, pix[beat_idx], 1'b1, 1'b0, 1'b1);
        sbq.delete();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_busy !== 1'b0 || o_vld !== 1'b0 || o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b out_valid=%b in_ready=%b required 0 0 0", o_busy, o_vld, o_rdy);
        end
        if (o_done) ndone++;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (o_done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses required 0", ndone);
        end
        beat_idx = 0;
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b1, pix[0], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (pop_s) begin
                got = 1'b1;
                e = sbq.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL abort_restart: got row=%0d col=%0d dat=%h required row=%0d col=%0d dat=%h",
                             obs.row, obs.col, obs.dat, e.row, e.col, e.dat);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL abort_restart_timeout: got no output required one beat");
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        beat_t e;
        fill_pix();
        beat_idx = 0;
        sbq.delete();
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400 && beat_idx < 50; i++) begin
            step(1'b1, pix[beat_idx], 1'b1, 1'b1, 1'b0);
            if (pop_s) begin
                e = sbq.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL busy_start: got row=%0d col=%0d required row=%0d col=%0d",
                             obs.row, obs.col, e.row, e.col);
                end
            end
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.in_ready_o, bus.out_valid_o, bus.out_last_o} !== 5'b0 ||
            bus.relu_in_o !== '0 || bus.out_data_o !== '0 ||
            bus.out_row_o !== 5'd0 || bus.out_col_o !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset: got ctrl=%b relu_in=%h data=%h row=%0d col=%0d required all 0",
                     {busy, done, bus.in_ready_o, bus.out_valid_o, bus.out_last_o},
                     bus.relu_in_o, bus.out_data_o, bus.out_row_o, bus.out_col_o);
        end
        start = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        sbq.delete();
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_full_frame();
        test_sign();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
